zdac_spi_writer: RTL and testbench

// - SPI write master for a 16-bit serial DAC. It is the transmit-side counterpart of the ADC capture path.
// - Accepts one sample per valid/ready handshake and shifts it out MSB first in a single CS-framed word.
// - Optionally pulses LDAC after each frame to update the DAC output.
// - Sits between the sample-processing logic and the DAC pins on the iCE40UP5K.

---
 rtl/zdac_spi_writer.sv | 183 ++++++++++++++++++
 tb/tb_zdac_spi_writer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/zdac_spi_writer.sv
// ---------------------------------------------------------------------------
// zdac_spi_writer
//   SPI write master for a 16-bit serial DAC. One sample is accepted per
//   iValid/oReady handshake and shifted out MSB first inside a single
//   CS_N-framed word. SCK idles low and the DAC samples DIN on SCK rising
//   edges. An optional LDAC_N strobe follows each frame.
//
//   Optional feature macro: ZDAC_LDAC_EN
//     defined   : after CS_N rises, wait one cycle, then pulse oLDAC_N low for
//                 LDAC_W cycles before the inter-frame gap.
//     undefined : oLDAC_N is constantly 1 and the gap starts at the CS_N rise.
//
// Ports
//   iClk     in   system clock
//   iRstN    in   asynchronous reset, active-low
//   iEn      in   block enable; low aborts any frame and holds the block idle
//   iData    in   sample to transmit, captured at the handshake
//   iValid   in   iData valid
//   oReady   out  block can accept a sample (idle and iEn=1)
//   oCS_N    out  DAC chip select, active-low
//   oSCK     out  serial clock, idles low
//   oSDI     out  serial data to DAC DIN
//   oLDAC_N  out  DAC load strobe, active-low
//   oDone    out  one-cycle pulse when a frame fully completes
// ---------------------------------------------------------------------------
module zdac_spi_writer #(
  parameter int DATA_W   = 16,
  parameter int SCK_DIV  = 1,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int IDLE_MIN = 4,
  parameter int LDAC_W   = 2
) (
  input  logic              iClk,
  input  logic              iRstN,
  input  logic              iEn,
  input  logic [DATA_W-1:0] iData,
  input  logic              iValid,
  output logic              oReady,
  output logic              oCS_N,
  output logic              oSCK,
  output logic              oSDI,
  output logic              oLDAC_N,
  output logic              oDone
);

  // The LDAC state spends one cycle with CS_N high before the strobe itself.
  localparam int LDAC_CYC = LDAC_W + 1;
  localparam int M1       = (SCK_DIV > CS_SETUP) ? SCK_DIV : CS_SETUP;
  localparam int M2       = (M1 > CS_HOLD) ? M1 : CS_HOLD;
  localparam int M3       = (M2 > IDLE_MIN) ? M2 : IDLE_MIN;
  localparam int CNT_MAX  = (M3 > LDAC_CYC) ? M3 : LDAC_CYC;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(SCK_DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(IDLE_MIN - 1);
  localparam logic [CNT_W-1:0] LDAC_LAST  = CNT_W'(LDAC_W);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_HOLD,
`ifdef ZDAC_LDAC_EN
    S_LDAC,
`endif
    S_GAP
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [CNT_W-1:0]  r_cnt;
  logic [BIT_W-1:0]  r_bit;
  logic [DATA_W-1:0] r_shift;
  logic              r_done;
  logic              w_accept;

  assign w_accept = (r_state == S_IDLE) && iEn && iValid;
  assign oDone    = r_done;

  // State register, phase counter, bit counter and shift register.
  // The phase counter restarts on every state change so each state measures
  // its own length; it is held at zero while idle.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if ((w_nextState != r_state) || (r_state == S_IDLE))
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;

      if (w_accept) begin
        r_shift <= iData;
        r_bit   <= '0;
      end else if ((r_state == S_SHIFT_HI) && (w_nextState == S_SHIFT_LO)) begin
        r_shift <= {r_shift[DATA_W-2:0], 1'b0};
        r_bit   <= r_bit + 1'b1;
      end

      // Done only on a genuine gap exit; a gap cut short by iEn=0 is an abort.
      r_done <= (r_state == S_GAP) && (r_cnt == GAP_LAST) && iEn;
    end
  end

  // Next-state and output decode. Outputs depend only on registered state so
  // an asynchronous reset drives them to their idle values immediately.
  // oReady is additionally qualified by iRstN so it reads 0 while in reset.
  always_comb begin
    w_nextState = r_state;
    oReady      = 1'b0;
    oCS_N       = 1'b1;
    oSCK        = 1'b0;
    oSDI        = 1'b0;
    oLDAC_N     = 1'b1;

    case (r_state)
      S_IDLE: begin
        oReady = iEn && iRstN;
        if (w_accept)
          w_nextState = S_SETUP;
      end
      S_SETUP: begin
        oCS_N = 1'b0;
        oSDI  = r_shift[DATA_W-1];
        if (r_cnt == SETUP_LAST)
          w_nextState = S_SHIFT_LO;
      end
      S_SHIFT_LO: begin
        oCS_N = 1'b0;
        oSDI  = r_shift[DATA_W-1];
        if (r_cnt == DIV_LAST)
          w_nextState = S_SHIFT_HI;
      end
      S_SHIFT_HI: begin
        oCS_N = 1'b0;
        oSCK  = 1'b1;
        oSDI  = r_shift[DATA_W-1];
        if (r_cnt == DIV_LAST)
          w_nextState = (r_bit == BIT_LAST) ? S_HOLD : S_SHIFT_LO;
      end
      S_HOLD: begin
        oCS_N = 1'b0;
        oSDI  = r_shift[DATA_W-1];
        if (r_cnt == HOLD_LAST) begin
`ifdef ZDAC_LDAC_EN
          w_nextState = S_LDAC;
`else
          w_nextState = S_GAP;
`endif
        end
      end
`ifdef ZDAC_LDAC_EN
      S_LDAC: begin
        // First cycle keeps LDAC_N high so it never overlaps CS_N low.
        oLDAC_N = (r_cnt == '0);
        if (r_cnt == LDAC_LAST)
          w_nextState = S_GAP;
      end
`endif
      S_GAP: begin
        if (r_cnt == GAP_LAST)
          w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase

    // Enable low overrides everything: abort on the next edge.
    if (!iEn)
      w_nextState = S_IDLE;
  end

endmodule

// File: tb/tb_zdac_spi_writer.sv
// ---------------------------------------------------------------------------
// tb_zdac_spi_writer
//   Two instances: dut0 with default timing, dut1 with SCK_DIV=3. A negedge
//   monitor predicts every output per cycle from a timing model built from the
//   frame arithmetic (offset from the handshake cycle), and also decodes the
//   bits seen on SCK rising edges. Follows the ZDAC_LDAC_EN build macro.
// ---------------------------------------------------------------------------
module tb_zdac_spi_writer;

  localparam int W        = 16;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int IDLE_MIN = 4;
  localparam int LDAC_W   = 2;
  localparam int DIV0     = 1;
  localparam int DIV1     = 3;
`ifdef ZDAC_LDAC_EN
  localparam int LDAC_EXTRA = 1 + LDAC_W;
`else
  localparam int LDAC_EXTRA = 0;
`endif

  logic         clk  = 1'b0;
  logic         rstN = 1'b0;
  logic         en    [2];
  logic         valid [2];
  logic [W-1:0] dat   [2];
  logic         ready [2];
  logic         csN   [2];
  logic         sck   [2];
  logic         sdi   [2];
  logic         ldacN [2];
  logic         done  [2];

  int nChecks = 0;
  int nFails  = 0;

  bit           act     [2];
  int           off     [2];
  logic [W-1:0] sent    [2];
  logic [W-1:0] cap     [2];
  int           edges   [2];
  logic         prevSck [2];
  int           hsCount [2];

  always #5 clk = ~clk;

  zdac_spi_writer #(.DATA_W(W), .SCK_DIV(DIV0), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD),
                    .IDLE_MIN(IDLE_MIN), .LDAC_W(LDAC_W)) dut0 (
    .iClk(clk), .iRstN(rstN), .iEn(en[0]), .iData(dat[0]), .iValid(valid[0]),
    .oReady(ready[0]), .oCS_N(csN[0]), .oSCK(sck[0]), .oSDI(sdi[0]),
    .oLDAC_N(ldacN[0]), .oDone(done[0]));

  zdac_spi_writer #(.DATA_W(W), .SCK_DIV(DIV1), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD),
                    .IDLE_MIN(IDLE_MIN), .LDAC_W(LDAC_W)) dut1 (
    .iClk(clk), .iRstN(rstN), .iEn(en[1]), .iData(dat[1]), .iValid(valid[1]),
    .oReady(ready[1]), .oCS_N(csN[1]), .oSCK(sck[1]), .oSDI(sdi[1]),
    .oLDAC_N(ldacN[1]), .oDone(done[1]));

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    nChecks++;
    if (got !== want) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  // Offset of the CS_N-high cycle on which oDone pulses.
  function automatic int frameLen(input int div);
    return CS_SETUP + 2 * div * W + CS_HOLD + 1 + LDAC_EXTRA + IDLE_MIN;
  endfunction

  // Expected {csN, sck, sdi, ldacN, done} at a given offset from the handshake.
  function automatic logic [4:0] modelAt(input int o, input logic [W-1:0] w, input int div,
                                         output logic sdiCare);
    int sh0, shN, csEnd, s, bitIdx;
    logic eCs, eSck, eSdi, eLdac, eDone;
    sh0    = CS_SETUP + 1;
    shN    = 2 * div * W;
    csEnd  = CS_SETUP + shN + CS_HOLD;
    s      = o - sh0;
    eCs    = !(o >= 1 && o <= csEnd);
    eSck   = (s >= 0) && (s < shN) && (((s / div) % 2) == 1);
    bitIdx = (s >= 0 && s < shN) ? (s / div) / 2 : 0;
    eSdi   = eCs ? 1'b0 : w[W-1-bitIdx];
    sdiCare = !(o >= sh0 + shN && o <= csEnd);
    eLdac  = !(LDAC_EXTRA > 0 && o >= csEnd + 2 && o <= csEnd + 1 + LDAC_W);
    eDone  = (o == frameLen(div));
    return {eCs, eSck, eSdi, eLdac, eDone};
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin : perDut
      int div;
      int len;
      logic care;
      logic expReady;
      logic [4:0] e;
      logic [4:0] o;
      div = (d == 0) ? DIV0 : DIV1;
      len = frameLen(div);
      o   = {csN[d], sck[d], sdi[d], ldacN[d], done[d]};
      if (!rstN) begin
        checkOutput($sformatf("dut%0d in reset", d), 32'({ready[d], o}), 32'(6'b010010));
        act[d]     = 1'b0;
        prevSck[d] = 1'b0;
      end else begin
        care = 1'b1;
        if (act[d]) begin
          off[d]++;
          e = modelAt(off[d], sent[d], div, care);
        end else begin
          e = 5'b10010;
        end
        expReady = en[d] && !(act[d] && off[d] < len);
        if (act[d] && sck[d] && !prevSck[d]) begin
          cap[d] = {cap[d][W-2:0], sdi[d]};
          edges[d]++;
        end
        if (!care) begin
          e[2] = 1'b0;
          o[2] = 1'b0;
        end
        checkOutput($sformatf("dut%0d pins off=%0d", d, act[d] ? off[d] : -1),
                    32'({ready[d], o}), 32'({expReady, e}));
        if (act[d] && off[d] == len) begin
          checkOutput($sformatf("dut%0d decoded word", d), 32'(cap[d]), 32'(sent[d]));
          checkOutput($sformatf("dut%0d rising edges", d), 32'(edges[d]), 32'(W));
          act[d] = 1'b0;
        end
        if (act[d] && !en[d])
          act[d] = 1'b0;
        if (!act[d] && valid[d] && expReady) begin
          act[d]   = 1'b1;
          off[d]   = 0;
          sent[d]  = dat[d];
          cap[d]   = '0;
          edges[d] = 0;
          hsCount[d]++;
        end
        prevSck[d] = sck[d];
      end
    end
  end

  // Offers one word; returns one cycle after the handshake cycle.
  task automatic applyStimulus(input int d, input logic [W-1:0] w);
    int start;
    start = hsCount[d];
    @(posedge clk); #1;
    valid[d] = 1'b1;
    dat[d]   = w;
    for (int i = 0; i < 400 && hsCount[d] == start; i++) @(negedge clk);
    checkOutput($sformatf("dut%0d handshake", d), 32'(hsCount[d] - start), 32'd1);
    @(posedge clk); #1;
    valid[d] = 1'b0;
    dat[d]   = W'($urandom);
  endtask

  // Two words with iValid held high throughout.
  task automatic sendPair(input int d, input logic [W-1:0] w1, input logic [W-1:0] w2);
    int start;
    start = hsCount[d];
    @(posedge clk); #1;
    valid[d] = 1'b1;
    dat[d]   = w1;
    for (int i = 0; i < 400 && hsCount[d] < start + 1; i++) @(negedge clk);
    @(posedge clk); #1;
    dat[d] = w2;
    for (int i = 0; i < 400 && hsCount[d] < start + 2; i++) @(negedge clk);
    checkOutput($sformatf("dut%0d pair handshakes", d), 32'(hsCount[d] - start), 32'd2);
    @(posedge clk); #1;
    valid[d] = 1'b0;
    dat[d]   = W'($urandom);
  endtask

  task automatic waitIdle(input int d);
    for (int i = 0; i < 400 && act[d]; i++) @(negedge clk);
    checkOutput($sformatf("dut%0d frame finished", d), 32'(act[d]), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      en[d]    = 1'b1;
      valid[d] = 1'b0;
      dat[d]   = '0;
    end
    rstN = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rstN = 1'b1;

    applyStimulus(0, 16'hA55A);
    waitIdle(0);

    sendPair(0, 16'h0001, 16'h8000);
    waitIdle(0);

    applyStimulus(1, 16'hFFFF);
    waitIdle(1);
    applyStimulus(1, 16'h0000);
    waitIdle(1);

    for (int i = 0; i < 10; i++) begin
      int d;
      d = $urandom_range(0, 1);
      applyStimulus(d, W'($urandom));
      if ($urandom_range(0, 1) == 1) waitIdle(d);
    end
    waitIdle(0);
    waitIdle(1);

    // Abort one cycle after the 8th SCK rise (rise k=7 at offset 18).
    applyStimulus(0, 16'hBEEF);
    repeat (17) @(posedge clk);
    @(posedge clk); #1;
    en[0] = 1'b0;
    repeat (5) @(posedge clk); #1;
    en[0] = 1'b1;
    applyStimulus(0, 16'h1234);
    waitIdle(0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, W'($urandom));
      repeat ($urandom_range(0, 45)) @(posedge clk);
      #1 en[0] = 1'b0;
      repeat (2) @(posedge clk);
      #1 en[0] = 1'b1;
      waitIdle(0);
    end

    // Asynchronous reset while SCK is high (offset 4).
    applyStimulus(0, 16'hC3C3);
    repeat (3) @(posedge clk);
    #1 rstN = 1'b0;
    #1;
    checkOutput("dut0 async reset pins",
                32'({ready[0], csN[0], sck[0], sdi[0], ldacN[0], done[0]}), 32'(6'b010010));
    @(negedge clk);
    @(posedge clk); #1;
    rstN = 1'b1;
    applyStimulus(0, 16'hC3C3);
    waitIdle(0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
